// File: rtl/slurm32_cpu_prefetch.sv
// slurm32_cpu_prefetch
// Instruction prefetch queue in front of slurm32_cpu_pipeline.
// - Owns the fetch PC and issues word fetches to the instruction memory.
// - Keeps an address-tag queue of in-flight requests and an in-order show-ahead
//   FIFO of returned {address, word} pairs.
// - A flush (branch / interrupt / debugger PC load) empties the FIFO, counts the
//   in-flight responses that must be thrown away, and restarts at flush_address.
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   flush, flush_address      load a new fetch PC (word address)
//   instruction_request       pipeline consumes the head word this cycle
//   instruction_valid/_in/_address_in   head word presented to the pipeline
//   mem_request, mem_address  fetch request to instruction memory
//   mem_ready                 memory accepts the request this cycle
//   mem_valid, mem_data       in-order responses, latency >= 1
//   outstanding               accepted requests not yet returned (debug)
//
// Optional feature, macro SLURM32_PREFETCH_BYPASS_EN:
//   defined   -> a response arriving while the FIFO is empty is presented in the
//                same cycle (0-cycle response-to-output latency)
//   undefined -> all outputs come from the FIFO (1-cycle latency), default build

module slurm32_cpu_prefetch #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [29:0] RESET_ADDR = 30'd0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   flush,
  input  logic [29:0]            flush_address,
  input  logic                   instruction_request,
  output logic                   instruction_valid,
  output logic [31:0]            instruction_in,
  output logic [29:0]            instruction_address_in,
  output logic                   mem_request,
  output logic [29:0]            mem_address,
  input  logic                   mem_ready,
  input  logic                   mem_valid,
  input  logic [31:0]            mem_data,
  output logic [$clog2(DEPTH):0] outstanding
);

  localparam int unsigned AW = $clog2(DEPTH);  // pointer width
  localparam int unsigned CW = AW + 1;         // counter width, holds 0..DEPTH
  localparam int unsigned SW = CW + 1;         // width of count + outstanding

  // State
  logic [29:0]   fetch_pc;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] tag_rd;
  logic [AW-1:0] tag_wr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] discard;

  // Storage (no reset needed: contents are only read when marked valid)
  logic [31:0]   fifo_data [DEPTH];
  logic [29:0]   fifo_addr [DEPTH];
  logic [29:0]   tag_q     [DEPTH];

  // Next-state / control
  logic          empty;
  logic [SW-1:0] sum;
  logic          accept;
  logic          resp;
  logic          drop;
  logic          bypass;
  logic          bypass_pop;
  logic          push;
  logic          head_pop;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] count_nxt;

  assign empty       = (count == '0);
  assign mem_address = fetch_pc;
  assign outstanding = outstanding_q;

  // Issue, response and FIFO control
  always_comb begin
    sum         = SW'(count) + SW'(outstanding_q);
    // Buffered plus in-flight words never exceed DEPTH, so the FIFO cannot overflow.
    mem_request = !RST && !flush && (sum < SW'(DEPTH));
    accept      = mem_request && mem_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    resp        = mem_valid && (outstanding_q != '0);
    drop        = resp && (flush || (discard != '0));
`ifdef SLURM32_PREFETCH_BYPASS_EN
    bypass      = empty && resp && !drop;
`else
    bypass      = 1'b0;
`endif
    bypass_pop  = bypass && instruction_request;
    // A word consumed straight from the memory bus is never buffered.
    push        = resp && !drop && !bypass_pop;
    head_pop    = !empty && instruction_request && !flush;

    outstanding_nxt = outstanding_q;
    case ({accept, resp})
      2'b10:   outstanding_nxt = outstanding_q + CW'(1);
      2'b01:   outstanding_nxt = outstanding_q - CW'(1);
      default: outstanding_nxt = outstanding_q;
    endcase

    count_nxt = count;
    case ({push, head_pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Head word presentation (show-ahead); zero when nothing is valid
  always_comb begin
    instruction_valid      = !empty;
    instruction_in         = empty ? 32'd0 : fifo_data[rd_ptr];
    instruction_address_in = empty ? 30'd0 : fifo_addr[rd_ptr];
`ifdef SLURM32_PREFETCH_BYPASS_EN
    if (bypass) begin
      instruction_valid      = 1'b1;
      instruction_in         = mem_data;
      instruction_address_in = tag_q[tag_rd];
    end
`endif
  end

  // Control registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc      <= RESET_ADDR;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      tag_rd        <= '0;
      tag_wr        <= '0;
      count         <= '0;
      outstanding_q <= '0;
      discard       <= '0;
    end else begin
      outstanding_q <= outstanding_nxt;
      if (accept) tag_wr <= tag_wr + AW'(1);
      if (resp)   tag_rd <= tag_rd + AW'(1);
      if (flush) begin
        // Everything still in flight after this cycle belongs to the old stream.
        fetch_pc <= flush_address;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        discard  <= outstanding_nxt;
      end else begin
        if (accept)                   fetch_pc <= fetch_pc + 30'd1;
        if (resp && (discard != '0))  discard  <= discard - CW'(1);
        if (push)                     wr_ptr   <= wr_ptr + AW'(1);
        if (head_pop)                 rd_ptr   <= rd_ptr + AW'(1);
        count <= count_nxt;
      end
    end
  end

  // Tag queue and FIFO storage writes
  always_ff @(posedge CLK) begin
    if (accept) tag_q[tag_wr] <= fetch_pc;
    if (push) begin
      fifo_data[wr_ptr] <= mem_data;
      fifo_addr[wr_ptr] <= tag_q[tag_rd];
    end
  end

  // Protocol and invariant checks
  a_no_orphan_response: assert property (@(posedge CLK) disable iff (RST)
    !(mem_valid && (outstanding_q == '0)));
  a_outstanding_bound: assert property (@(posedge CLK) disable iff (RST)
    outstanding_q <= CW'(DEPTH));
  a_discard_bound: assert property (@(posedge CLK) disable iff (RST)
    discard <= outstanding_q);
  a_occupancy_bound: assert property (@(posedge CLK) disable iff (RST)
    sum <= SW'(DEPTH));

endmodule

// File: tb/tb_slurm32_cpu_prefetch.sv
// Testbench for slurm32_cpu_prefetch: drives a latency-configurable instruction
// memory and a pipeline consumer, and checks every cycle against a queue-based
// model of buffered words, in-flight fetches and the expected address stream.
module tb_slurm32_cpu_prefetch;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned OW    = $clog2(DEPTH) + 1;
`ifdef SLURM32_PREFETCH_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          flush;
  logic [29:0]   flush_address;
  logic          instruction_request;
  logic          instruction_valid;
  logic [31:0]   instruction_in;
  logic [29:0]   instruction_address_in;
  logic          mem_request;
  logic [29:0]   mem_address;
  logic          mem_ready;
  logic          mem_valid;
  logic [31:0]   mem_data;
  logic [OW-1:0] outstanding;

  slurm32_cpu_prefetch dut (
    .CLK                    (CLK),
    .RST                    (RST),
    .flush                  (flush),
    .flush_address          (flush_address),
    .instruction_request    (instruction_request),
    .instruction_valid      (instruction_valid),
    .instruction_in         (instruction_in),
    .instruction_address_in (instruction_address_in),
    .mem_request            (mem_request),
    .mem_address            (mem_address),
    .mem_ready              (mem_ready),
    .mem_valid              (mem_valid),
    .mem_data               (mem_data),
    .outstanding            (outstanding)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [29:0] addr;
    int          due;
  } pend_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  pend_t       pending [$];
  logic [29:0] fifo_q  [$];
  int          disc;
  logic [29:0] exp_pc;
  logic [29:0] exp_next;
  logic [29:0] acc_log  [$];
  int          acc_cyc  [$];
  logic [29:0] pop_log  [$];
  logic [31:0] pop_data [$];
  int          pop_cyc  [$];
  logic        obs_valid;
  logic        obs_req;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    case (a)
      30'd0:   return 32'h30010003;
      30'd1:   return 32'h30020007;
      30'd2:   return 32'h21030102;
      default: return {a, 2'b11} ^ 32'hC3A50F00;
    endcase
  endfunction

  task automatic clear_logs();
    acc_log.delete(); acc_cyc.delete();
    pop_log.delete(); pop_data.delete(); pop_cyc.delete();
  endtask

  // One clock cycle: memory answers, outputs are checked, the model advances.
  task automatic step(input logic fl, input logic [29:0] fa);
    pend_t       p;
    logic        resp, acc, exp_v, exp_r, byp, popped;
    logic [29:0] rtag, exp_head;
    int          o_m;
    flush = fl;
    flush_address = fa;
    o_m = pending.size();
    tests++;
    if (outstanding !== OW'(o_m)) begin
      fails++; $display("FAIL outstanding cyc=%0d: got %0d expected %0d", cyc, outstanding, o_m);
    end
    tests++;
    if (outstanding > OW'(DEPTH)) begin
      fails++; $display("FAIL outstanding_bound cyc=%0d: got %0d limit %0d", cyc, outstanding, DEPTH);
    end
    resp = 1'b0;
    rtag = '0;
    if (pending.size() != 0 && pending[0].due <= cyc) begin
      p = pending.pop_front();
      resp = 1'b1;
      rtag = p.addr;
    end
    mem_valid = resp;
    mem_data  = resp ? mem_word(rtag) : $urandom();
    #1;
    exp_r = !fl && (fifo_q.size() + o_m < DEPTH);
    byp = 1'b0;
`ifdef SLURM32_PREFETCH_BYPASS_EN
    byp = resp && (fifo_q.size() == 0) && (disc == 0) && !fl;
`endif
    exp_v = (fifo_q.size() != 0) || byp;
    exp_head = (fifo_q.size() != 0) ? fifo_q[0] : rtag;
    tests++;
    if (mem_request !== exp_r) begin
      fails++; $display("FAIL mem_request cyc=%0d: got %b expected %b", cyc, mem_request, exp_r);
    end
    tests++;
    if (mem_address !== exp_pc) begin
      fails++; $display("FAIL mem_address cyc=%0d: got %h expected %h", cyc, mem_address, exp_pc);
    end
    tests++;
    if (instruction_valid !== exp_v) begin
      fails++; $display("FAIL instruction_valid cyc=%0d: got %b expected %b", cyc, instruction_valid, exp_v);
    end
    if (exp_v) begin
      tests++;
      if (instruction_address_in !== exp_head) begin
        fails++; $display("FAIL head_address cyc=%0d: got %h expected %h", cyc, instruction_address_in, exp_head);
      end
      tests++;
      if (instruction_in !== mem_word(exp_head)) begin
        fails++; $display("FAIL head_data cyc=%0d: got %h expected %h", cyc, instruction_in, mem_word(exp_head));
      end
    end
    obs_valid = instruction_valid;
    obs_req   = mem_request;
    acc = mem_request && mem_ready;
    if (acc) begin
      p.addr = mem_address;
      p.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
      pending.push_back(p);
      acc_log.push_back(mem_address);
      acc_cyc.push_back(cyc);
    end
    popped = exp_v && instruction_request && !fl;
    if (fl) begin
      fifo_q.delete();
      disc     = o_m - (resp ? 1 : 0);
      exp_pc   = fa;
      exp_next = fa;
    end else begin
      if (acc) exp_pc = exp_pc + 30'd1;
      if (popped) begin
        tests++;
        if (instruction_address_in !== exp_next) begin
          fails++; $display("FAIL address_sequence cyc=%0d: got %h expected %h", cyc, instruction_address_in, exp_next);
        end
        exp_next = exp_next + 30'd1;
        pop_log.push_back(instruction_address_in);
        pop_data.push_back(instruction_in);
        pop_cyc.push_back(cyc);
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      end
      if (resp) begin
        if (disc > 0) disc--;
        else if (!(byp && popped)) fifo_q.push_back(rtag);
      end
    end
    @(negedge CLK);
    cyc++;
  endtask

  task automatic test_reset();
    RST = 1'b1; flush = 1'b0; flush_address = '0;
    instruction_request = 1'b0; mem_ready = 1'b0;
    mem_valid = 1'b0; mem_data = '0;
    pending.delete();
    repeat (2) @(negedge CLK);
    #1;
    tests++;
    if (instruction_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", instruction_valid); end
    tests++;
    if (instruction_in !== 32'd0) begin fails++; $display("FAIL reset_data: got %h expected 0", instruction_in); end
    tests++;
    if (instruction_address_in !== 30'd0) begin fails++; $display("FAIL reset_addr: got %h expected 0", instruction_address_in); end
    tests++;
    if (mem_request !== 1'b0) begin fails++; $display("FAIL reset_mem_request: got %b expected 0", mem_request); end
    tests++;
    if (mem_address !== 30'd0) begin fails++; $display("FAIL reset_mem_address: got %h expected 0", mem_address); end
    tests++;
    if (outstanding !== '0) begin fails++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    RST = 1'b0;
    fifo_q.delete();
    disc = 0; exp_pc = 30'd0; exp_next = 30'd0; cyc = 0;
    clear_logs();
  endtask

  task automatic test_stream();
    logic [31:0] words [3];
    words = '{32'h30010003, 32'h30020007, 32'h21030102};
    test_reset();
    lat_lo = 1; lat_hi = 1; mem_ready = 1'b1; instruction_request = 1'b1;
    repeat (8) step(1'b0, '0);
    tests++;
    if (acc_log.size() < 3 || pop_log.size() < 3) begin
      fails++; $display("FAIL stream_count: got %0d/%0d expected >=3", acc_log.size(), pop_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (acc_log[i] !== 30'(i) || acc_cyc[i] != i) begin
          fails++; $display("FAIL stream_issue%0d: got %h@%0d expected %h@%0d", i, acc_log[i], acc_cyc[i], i, i);
        end
        tests++;
        if (pop_log[i] !== 30'(i) || pop_data[i] !== words[i] || pop_cyc[i] != 1 + LAT + i) begin
          fails++; $display("FAIL stream_word%0d: got %h/%h@%0d expected %h/%h@%0d",
                            i, pop_log[i], pop_data[i], pop_cyc[i], i, words[i], 1 + LAT + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    test_reset();
    lat_lo = 1; lat_hi = 2; mem_ready = 1'b1; instruction_request = 1'b0;
    repeat (20) step(1'b0, '0);
    #1;
    tests++;
    if (acc_log.size() != DEPTH) begin fails++; $display("FAIL bp_accepts: got %0d expected %0d", acc_log.size(), DEPTH); end
    tests++;
    if (outstanding !== '0) begin fails++; $display("FAIL bp_outstanding: got %0d expected 0", outstanding); end
    tests++;
    if (mem_request !== 1'b0) begin fails++; $display("FAIL bp_mem_request: got %b expected 0", mem_request); end
    clear_logs();
    instruction_request = 1'b1;
    repeat (8) step(1'b0, '0);
    tests++;
    if (pop_log.size() < 4 || acc_log.size() < 1) begin
      fails++; $display("FAIL bp_release: got %0d pops %0d issues expected >=4 >=1", pop_log.size(), acc_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (pop_log[i] !== 30'(i)) begin fails++; $display("FAIL bp_pop%0d: got %h expected %h", i, pop_log[i], i); end
      end
      tests++;
      if (acc_log[0] !== 30'd4) begin fails++; $display("FAIL bp_resume: got %h expected 4", acc_log[0]); end
    end
  endtask

  task automatic test_flush_late();
    int n;
    test_reset();
    lat_lo = 3; lat_hi = 3; mem_ready = 1'b1; instruction_request = 1'b1;
    n = 0;
    while (outstanding !== OW'(2) && n < 20) begin step(1'b0, '0); n++; end
    tests++;
    if (n == 20) begin fails++; $display("FAIL flush_late_wait: got timeout expected outstanding 2"); end
    clear_logs();
    step(1'b1, 30'h40);
    repeat (12) step(1'b0, '0);
    tests++;
    if (pop_log.size() == 0) begin
      fails++; $display("FAIL flush_late_first: got no output expected %h", 30'h40);
    end else if (pop_log[0] !== 30'h40 || pop_data[0] !== mem_word(30'd64)) begin
      fails++; $display("FAIL flush_late_first: got %h/%h expected %h/%h", pop_log[0], pop_data[0], 30'h40, mem_word(30'd64));
    end
  endtask

  task automatic test_flush_collide();
    test_reset();
    lat_lo = 1; lat_hi = 1; mem_ready = 1'b1; instruction_request = 1'b1;
    repeat (5) step(1'b0, '0);
    step(1'b1, 30'h123);
    tests++;
    if (obs_valid !== 1'b1) begin fails++; $display("FAIL collide_pop: got %b expected 1", obs_valid); end
    tests++;
    if (obs_req !== 1'b0) begin fails++; $display("FAIL collide_req: got %b expected 0", obs_req); end
    flush = 1'b0; mem_valid = 1'b0;
    #1;
    tests++;
    if (instruction_valid !== 1'b0) begin fails++; $display("FAIL collide_empty: got %b expected 0", instruction_valid); end
    tests++;
    if (mem_request !== 1'b1 || mem_address !== 30'h123) begin
      fails++; $display("FAIL collide_refetch: got %b/%h expected 1/%h", mem_request, mem_address, 30'h123);
    end
    clear_logs();
    repeat (6) step(1'b0, '0);
    tests++;
    if (pop_log.size() == 0 || pop_log[0] !== 30'h123) begin
      fails++; $display("FAIL collide_first: got %0d words expected first %h", pop_log.size(), 30'h123);
    end
  endtask

  task automatic test_wrap();
    test_reset();
    lat_lo = 1; lat_hi = 2; mem_ready = 1'b1; instruction_request = 1'b1;
    step(1'b1, 30'h3FFFFFFF);
    repeat (6) step(1'b0, '0);
    tests++;
    if (acc_log.size() < 2 || acc_log[0] !== 30'h3FFFFFFF || acc_log[1] !== 30'h0) begin
      fails++; $display("FAIL wrap_issue: got %0d issues expected 3FFFFFFF then 0", acc_log.size());
    end
  endtask

  task automatic test_random();
    logic        fl;
    logic [29:0] fa;
    test_reset();
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        test_reset();
        lat_lo = 1; lat_hi = 4;
      end
      mem_ready = 1'($urandom_range(0, 1));
      instruction_request = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 99) < 3);
      fa = 30'($urandom);
      if ($urandom_range(0, 1) == 1) fa = 30'h3FFFFFFF - 30'($urandom_range(0, 3));
      step(fl, fa);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_late();
    test_flush_collide();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
